// File: rtl/self_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : self_sync_pkg
// Description : Shared types, tap set and byte-parallel recurrence for the
//               x^8+x^6+x^5+x^4+1 self-synchronizing scrambler pair.
// Revision    : 1.0 - initial release
// ============================================================================
package self_sync_pkg;

    typedef enum logic {
        SS_SCRAMBLE   = 1'b0,
        SS_DESCRAMBLE = 1'b1
    } ss_mode_e;

    localparam int          c_NUM_TAPS         = 4;
    localparam int          c_TAPS [c_NUM_TAPS] = '{4, 5, 6, 8};
    localparam logic [7:0]  c_SEED_DEFAULT     = 8'hFF;

    // seq[0..7] holds history s(-8)..s(-1); seq[8+k] holds the stream bit of step k.
    // The scrambler feeds back its output, the descrambler feeds back its input.
    function automatic logic [7:0] ss_byte(input logic [7:0] data,
                                           input logic [7:0] hist,
                                           input ss_mode_e   mode);
        logic [15:0] seq;
        logic [7:0]  res;
        logic        fb;
        seq = '0;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            seq[4'(i)] = hist[3'(7 - i)];
        end
        for (int k = 0; k < 8; k++) begin
            fb = 1'b0;
            for (int t = 0; t < c_NUM_TAPS; t++) begin
                fb = fb ^ seq[4'(k + 8 - c_TAPS[t])];
            end
            res[3'(7 - k)] = data[3'(7 - k)] ^ fb;
            seq[4'(k + 8)] = (mode == SS_SCRAMBLE) ? res[3'(7 - k)] : data[3'(7 - k)];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/self_sync_scrambler_link_if.sv
`default_nettype none
// ============================================================================
// Module      : self_sync_scrambler_link_if
// Description : Loopback link bundle: plaintext in, scrambled and recovered
//               streams out.
// Revision    : 1.0 - initial release
// ============================================================================
interface self_sync_scrambler_link_if;

    logic       enable;
    logic [7:0] din;
    logic       tx_valid;
    logic [7:0] tx_dout;
    logic [7:0] tx_lfsr;
    logic       rx_dout_valid;
    logic [7:0] rx_dout;
    logic [7:0] rx_lfsr;

    modport master (
        output enable, din,
        input  tx_valid, tx_dout, tx_lfsr, rx_dout_valid, rx_dout, rx_lfsr
    );

    modport slave (
        input  enable, din,
        output tx_valid, tx_dout, tx_lfsr, rx_dout_valid, rx_dout, rx_lfsr
    );

endinterface
`default_nettype wire

// File: rtl/self_sync_descrambler.sv
`default_nettype none
// ============================================================================
// Module      : self_sync_descrambler
// Description : Byte-parallel self-synchronizing descrambler; history is the
//               received stream, so it relocks after one valid byte.
// Revision    : 1.0 - initial release
// ============================================================================
module self_sync_descrambler
    import self_sync_pkg::*;
#(
    parameter logic [7:0] SEED = c_SEED_DEFAULT
) (
    input  wire logic       clock,
    input  wire logic       resetn,
    input  wire logic       enable,
    input  wire logic [7:0] din,
    input  wire logic       valid,
    output logic      [7:0] dout,
    output logic            dout_valid,
    output logic      [7:0] lfsr
);

    logic [7:0] w_descrambled;
    logic [7:0] r_dout;
    logic [7:0] r_lfsr;
    logic       r_dout_valid;

    ss_byte_core #(.MODE(SS_DESCRAMBLE)) u_core (
        .i_data   (din),
        .i_hist   (r_lfsr),
        .o_result (w_descrambled)
    );

    always_ff @(posedge clock) begin
        if (resetn) begin
            r_dout       <= 8'h00;
            r_lfsr       <= SEED;
            r_dout_valid <= 1'b0;
        end else if (enable && valid) begin
            r_dout       <= w_descrambled;
            r_lfsr       <= din;
            r_dout_valid <= 1'b1;
        end else begin
            r_dout_valid <= 1'b0;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign lfsr       = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/self_sync_scrambler.sv
`default_nettype none
// ============================================================================
// Module      : self_sync_scrambler
// Description : Byte-parallel self-synchronizing scrambler, one byte per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module self_sync_scrambler
    import self_sync_pkg::*;
#(
    parameter logic [7:0] SEED = c_SEED_DEFAULT
) (
    input  wire logic       clock,
    input  wire logic       resetn,
    input  wire logic       enable,
    input  wire logic [7:0] din,
    output logic            valid,
    output logic      [7:0] dout,
    output logic      [7:0] lfsr
);

    logic [7:0] w_scrambled;
    logic [7:0] r_dout;
    logic [7:0] r_lfsr;
    logic       r_valid;

    ss_byte_core #(.MODE(SS_SCRAMBLE)) u_core (
        .i_data   (din),
        .i_hist   (r_lfsr),
        .o_result (w_scrambled)
    );

    // resetn is active-high despite its name
    always_ff @(posedge clock) begin
        if (resetn) begin
            r_dout  <= 8'h00;
            r_lfsr  <= SEED;
            r_valid <= 1'b0;
        end else if (enable) begin
            r_dout  <= w_scrambled;
            r_lfsr  <= w_scrambled;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign valid = r_valid;
    assign dout  = r_dout;
    assign lfsr  = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/ss_byte_core.sv
`default_nettype none
// ============================================================================
// Module      : ss_byte_core
// Description : Combinational 8-bit scramble/descramble step selected by MODE.
// Revision    : 1.0 - initial release
// ============================================================================
module ss_byte_core
    import self_sync_pkg::*;
#(
    parameter ss_mode_e MODE = SS_SCRAMBLE
) (
    input  wire logic [7:0] i_data,
    input  wire logic [7:0] i_hist,
    output logic      [7:0] o_result
);

    assign o_result = ss_byte(i_data, i_hist, MODE);

endmodule
`default_nettype wire

// File: rtl/self_sync_scrambler_link.sv
`default_nettype none
// ============================================================================
// Module      : self_sync_scrambler_link
// Description : Loopback wrapper: scrambler output feeds the descrambler.
// Revision    : 1.0 - initial release
// ============================================================================
module self_sync_scrambler_link
    import self_sync_pkg::*;
#(
    parameter logic [7:0] SEED    = c_SEED_DEFAULT,
    parameter logic [7:0] RX_SEED = SEED
) (
    input  wire logic                   clock,
    input  wire logic                   resetn,
    self_sync_scrambler_link_if.slave   link
);

    self_sync_scrambler #(.SEED(SEED)) u_scrambler (
        .clock  (clock),
        .resetn (resetn),
        .enable (link.enable),
        .din    (link.din),
        .valid  (link.tx_valid),
        .dout   (link.tx_dout),
        .lfsr   (link.tx_lfsr)
    );

    // The receive side is qualified by the scrambler's valid alone, so the
    // last byte before a transmit gap is still consumed.
    self_sync_descrambler #(.SEED(RX_SEED)) u_descrambler (
        .clock      (clock),
        .resetn     (resetn),
        .enable     (1'b1),
        .din        (link.tx_dout),
        .valid      (link.tx_valid),
        .dout       (link.rx_dout),
        .dout_valid (link.rx_dout_valid),
        .lfsr       (link.rx_lfsr)
    );

endmodule
`default_nettype wire

// File: tb/tb_self_sync_scrambler_link.sv
`default_nettype none
// ============================================================================
// Module      : tb_self_sync_scrambler_link
// Description : Directed vector bench for the scrambler/descrambler loopback.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_self_sync_scrambler_link;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] din;
        logic       chk_tx;
        logic [7:0] tx_dout;
        logic [7:0] tx_lfsr;
        logic       tx_v;
        logic [7:0] rx_dout;
        logic       rx_v;
        logic [7:0] rx_lfsr;
    } vec_t;

    localparam int c_NUM_VECS = 13;
    localparam int c_NUM_PT   = 6;

    logic clock  = 1'b0;
    logic resetn = 1'b1;

    always #5 clock = ~clock;

    self_sync_scrambler_link_if link_if ();
    self_sync_scrambler_link_if mis_if ();

    assign mis_if.enable = link_if.enable;
    assign mis_if.din    = link_if.din;

    self_sync_scrambler_link dut (
        .clock  (clock),
        .resetn (resetn),
        .link   (link_if.slave)
    );

    self_sync_scrambler_link #(.SEED(8'hFF), .RX_SEED(8'h00)) dut_mis (
        .clock  (clock),
        .resetn (resetn),
        .link   (mis_if.slave)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    vec_t       vecs [c_NUM_VECS];
    logic [7:0] pt   [c_NUM_PT];
    logic [7:0] exp_mis;

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        link_if.enable = 1'b0;
        link_if.din    = 8'h00;

        //            rst   en    din    chk   tx_dout tx_lfsr tx_v  rx_dout rx_v  rx_lfsr
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00,  8'hFF,  1'b0, 8'h00,  1'b0, 8'hFF};
        vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00,  8'hFF,  1'b0, 8'h00,  1'b0, 8'hFF};
        vecs[2]  = '{1'b0, 1'b1, 8'hAA, 1'b1, 8'hAC,  8'hAC,  1'b1, 8'h00,  1'b0, 8'hFF};
        vecs[3]  = '{1'b0, 1'b1, 8'hAA, 1'b1, 8'h17,  8'h17,  1'b1, 8'hAA,  1'b1, 8'hAC};
        vecs[4]  = '{1'b0, 1'b1, 8'hAA, 1'b1, 8'h2A,  8'h2A,  1'b1, 8'hAA,  1'b1, 8'h17};
        vecs[5]  = '{1'b0, 1'b0, 8'hAA, 1'b1, 8'h2A,  8'h2A,  1'b0, 8'hAA,  1'b1, 8'h2A};
        vecs[6]  = '{1'b0, 1'b0, 8'hAA, 1'b1, 8'h2A,  8'h2A,  1'b0, 8'hAA,  1'b0, 8'h2A};
        vecs[7]  = '{1'b0, 1'b0, 8'hAA, 1'b1, 8'h2A,  8'h2A,  1'b0, 8'hAA,  1'b0, 8'h2A};
        vecs[8]  = '{1'b0, 1'b1, 8'hAA, 1'b1, 8'hD0,  8'hD0,  1'b1, 8'hAA,  1'b0, 8'h2A};
        vecs[9]  = '{1'b0, 1'b1, 8'hAA, 1'b0, 8'h00,  8'h00,  1'b1, 8'hAA,  1'b1, 8'hD0};
        vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00,  8'hFF,  1'b0, 8'h00,  1'b0, 8'hFF};
        vecs[11] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h0B,  8'h0B,  1'b1, 8'h00,  1'b0, 8'hFF};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h0B,  8'h0B,  1'b0, 8'h00,  1'b1, 8'h0B};

        for (int i = 0; i < c_NUM_VECS; i++) begin
            resetn         = vecs[i].rst;
            link_if.enable = vecs[i].en;
            link_if.din    = vecs[i].din;
            step();
            if (vecs[i].chk_tx) begin
                chk8($sformatf("v%0d tx_dout", i), link_if.tx_dout, vecs[i].tx_dout);
                chk8($sformatf("v%0d tx_lfsr", i), link_if.tx_lfsr, vecs[i].tx_lfsr);
            end
            chk1($sformatf("v%0d tx_valid", i), link_if.tx_valid, vecs[i].tx_v);
            chk8($sformatf("v%0d rx_dout", i), link_if.rx_dout, vecs[i].rx_dout);
            chk1($sformatf("v%0d rx_valid", i), link_if.rx_dout_valid, vecs[i].rx_v);
            chk8($sformatf("v%0d rx_lfsr", i), link_if.rx_lfsr, vecs[i].rx_lfsr);
        end

        // Descrambler seeded 00 against a FF-seeded scrambler: the seed
        // difference corrupts bits 3,1,0 of the first byte only.
        pt[0] = 8'h3C; pt[1] = 8'h5A; pt[2] = 8'hC3;
        pt[3] = 8'h01; pt[4] = 8'h80; pt[5] = 8'hFF;

        resetn         = 1'b1;
        link_if.enable = 1'b0;
        step();
        step();
        chk8("mis reset rx_lfsr", mis_if.rx_lfsr, 8'h00);
        chk1("mis reset rx_valid", mis_if.rx_dout_valid, 1'b0);
        resetn = 1'b0;

        for (int i = 0; i < c_NUM_PT; i++) begin
            link_if.enable = 1'b1;
            link_if.din    = pt[i];
            step();
            if (i >= 1) begin
                exp_mis = (i == 1) ? (pt[0] ^ 8'h0B) : pt[i-1];
                chk1($sformatf("seq%0d rx_valid", i), link_if.rx_dout_valid, 1'b1);
                chk8($sformatf("seq%0d rx_dout", i), link_if.rx_dout, pt[i-1]);
                chk8($sformatf("seq%0d mis rx_dout", i), mis_if.rx_dout, exp_mis);
            end
        end
        link_if.enable = 1'b0;
        step();
        chk8("seq flush rx_dout", link_if.rx_dout, pt[c_NUM_PT-1]);
        chk8("seq flush mis rx_dout", mis_if.rx_dout, pt[c_NUM_PT-1]);
        chk1("seq flush tx_valid", link_if.tx_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
